// File: rtl/soc_pkg.sv
// Shared constants for the SOC memory/I-O subsystem: I/O register offsets,
// UART state encoding and status bit layout.
package soc_pkg;

    localparam int IO_LED_BIT         = 0;
    localparam int IO_UART_DATA_BIT   = 1;
    localparam int IO_UART_STATUS_BIT = 2;

    localparam int UART_BUSY_BIT = 0;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/soc_mem_io_uart_tx.sv
// 8N1 UART transmitter, BAUD_DIV clocks per bit. Accepts a byte only while idle;
// tx is registered so the line never glitches.
module uart_tx
    import soc_pkg::*;
#(
    parameter int BAUD_DIV = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(BAUD_DIV - 1);

    uart_state_e   r_state;
    uart_state_e   w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_next;
    logic [7:0]    r_data;
    logic [7:0]    w_data_next;
    logic          r_tx;
    logic          w_tx_next;
    logic          w_cnt_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= UART_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_data  <= w_data_next;
            r_tx    <= w_tx_next;
        end
    end

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_data_next  = r_data;
        case (r_state)
            UART_IDLE: begin
                if (start) begin
                    w_state_next = UART_START;
                    w_cnt_next   = RELOAD;
                    w_data_next  = data;
                end
            end
            UART_START: begin
                if (w_cnt_zero) begin
                    w_state_next = UART_DATA;
                    w_idx_next   = 3'd0;
                    w_cnt_next   = RELOAD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            UART_DATA: begin
                if (w_cnt_zero) begin
                    if (r_idx == 3'd7) begin
                        w_state_next = UART_STOP;
                    end
                    w_idx_next = r_idx + 3'd1;
                    w_cnt_next = RELOAD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            UART_STOP: begin
                if (w_cnt_zero) begin
                    w_state_next = UART_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: w_state_next = UART_IDLE;
        endcase
    end

    // Line level is decoded from the upcoming state so it lands in r_tx on the same edge.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            UART_START: w_tx_next = 1'b0;
            UART_DATA:  w_tx_next = w_data_next[w_idx_next];
            default:    w_tx_next = 1'b1;
        endcase
    end

    assign tx   = r_tx;
    assign busy = (r_state != UART_IDLE);

endmodule

// File: rtl/soc_mem_io.sv
// Processor-bus memory and I/O: byte-masked word RAM plus an I/O page with an
// LED register and a UART transmitter/status register.
module soc_mem_io
    import soc_pkg::*;
#(
    parameter int RAM_WORDS = 1536,
    parameter int IO_BIT    = 22,
    parameter int NUM_LED   = 8,
    parameter int BAUD_DIV  = 217
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        mem_addr,
    input  logic               mem_rstrb,
    output logic [31:0]        mem_rdata,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_wmask,
    output logic [NUM_LED-1:0] leds,
    output logic               uart_tx,
    output logic               uart_busy
);

    localparam int WORD_W = IO_BIT - 2;
    localparam int AW     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    logic [31:0]        r_ram [RAM_WORDS];
    logic [31:0]        r_rdata;
    logic [NUM_LED-1:0] r_leds;

    logic               w_io_sel;
    logic [WORD_W-1:0]  w_word;
    logic               w_in_range;
    logic [AW-1:0]      w_ram_idx;
    logic [2:0]         w_io_reg;
    logic               w_led_sel;
    logic               w_data_sel;
    logic               w_stat_sel;
    logic               w_ram_we;
    logic               w_uart_start;
    logic               w_uart_busy;
    logic               w_uart_tx;
    logic [31:0]        w_status;
    logic [31:0]        w_rdata_next;
    logic               w_unused_bits;

    assign w_io_sel   = mem_addr[IO_BIT];
    assign w_word     = mem_addr[IO_BIT-1:2];
    assign w_in_range = (32'(w_word) < 32'(RAM_WORDS));
    assign w_ram_idx  = w_word[AW-1:0];
    assign w_io_reg   = mem_addr[4:2];
    assign w_led_sel  = (w_io_reg == 3'(1 << IO_LED_BIT));
    assign w_data_sel = (w_io_reg == 3'(1 << IO_UART_DATA_BIT));
    assign w_stat_sel = (w_io_reg == 3'(1 << IO_UART_STATUS_BIT));
    assign w_ram_we   = !w_io_sel && w_in_range && (mem_wmask != 4'b0000);
    assign w_uart_start = w_io_sel && w_data_sel && mem_wmask[0];
    assign w_unused_bits = ^{mem_addr, mem_wdata};

    // No reset on the array so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_status = '0;
        w_status[UART_BUSY_BIT] = w_uart_busy;
    end

    always_comb begin
        w_rdata_next = '0;
        if (w_io_sel) begin
            if (w_led_sel) begin
                w_rdata_next = 32'(r_leds);
            end else if (w_stat_sel) begin
                w_rdata_next = w_status;
            end
        end else if (w_in_range) begin
            w_rdata_next = r_ram[w_ram_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (mem_rstrb) begin
            r_rdata <= w_rdata_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_leds <= '0;
        end else if (w_io_sel && w_led_sel && mem_wmask[0]) begin
            r_leds <= mem_wdata[NUM_LED-1:0];
        end
    end

    uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart_tx (
        .clk  (clk),
        .rst  (rst),
        .data (mem_wdata[7:0]),
        .start(w_uart_start),
        .tx   (w_uart_tx),
        .busy (w_uart_busy)
    );

    assign mem_rdata = r_rdata;
    assign leds      = r_leds;
    assign uart_tx   = w_uart_tx;
    assign uart_busy = w_uart_busy;

endmodule

// File: tb/tb_soc_mem_io.sv
// Randomized bench for soc_mem_io against an array/arithmetic reference model
// of the RAM, LED register and UART frame timing.
module tb_soc_mem_io;

    localparam int RW  = 20;
    localparam int IOB = 22;
    localparam int NL  = 8;
    localparam int BD  = 4;

    localparam logic [31:0] A_LED  = 32'h0040_0004;
    localparam logic [31:0] A_UDAT = 32'h0040_0008;
    localparam logic [31:0] A_USTA = 32'h0040_0010;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   mem_addr;
    logic          mem_rstrb;
    logic [31:0]   mem_rdata;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic [NL-1:0] leds;
    logic          uart_tx;
    logic          uart_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]   m_ram [RW];
    logic [31:0]   m_rdata;
    logic [NL-1:0] m_leds;

    soc_mem_io #(
        .RAM_WORDS(RW),
        .IO_BIT   (IOB),
        .NUM_LED  (NL),
        .BAUD_DIV (BD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_addr (mem_addr),
        .mem_rstrb(mem_rstrb),
        .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .leds     (leds),
        .uart_tx  (uart_tx),
        .uart_busy(uart_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        mem_rstrb = 1'b0;
        mem_wmask = 4'b0000;
    endtask

    // One bus cycle to a RAM word; rdata is checked after the edge (also when it must hold).
    task automatic ram_op(input int w, input logic [31:0] d, input logic [3:0] m, input bit rd);
        mem_addr  = 32'(w) << 2;
        mem_wdata = d;
        mem_wmask = m;
        mem_rstrb = rd;
        if (rd) m_rdata = (w < RW) ? m_ram[w] : 32'h0;
        if (w < RW) begin
            for (int i = 0; i < 4; i++)
                if (m[i]) m_ram[w][8*i +: 8] = d[8*i +: 8];
        end
        tick();
        bus_idle();
        $display("[TB] ram w=%0d d=%h m=%b rd=%0d -> rdata=%h", w, d, m, rd, mem_rdata);
        check("ram_rdata", mem_rdata, m_rdata);
    endtask

    task automatic io_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        if (a == A_LED && m[0]) m_leds = d[NL-1:0];
        tick();
        bus_idle();
        $display("[TB] io write a=%h d=%h m=%b leds=%h", a, d, m, leds);
        check("leds", 32'(leds), 32'(m_leds));
    endtask

    task automatic io_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        tick();
        bus_idle();
        m_rdata = exp;
        $display("[TB] io read a=%h -> %h", a, mem_rdata);
        check(tag, mem_rdata, exp);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int slot;
        slot = k / BD;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Sends one byte and checks every cycle of the 10*BD frame; optionally tries a write mid-frame.
    task automatic frame(input logic [7:0] b, input bit drop_mid);
        logic [7:0] other;
        other = ~b;
        mem_addr  = A_UDAT;
        mem_wdata = {24'h0, b};
        mem_wmask = 4'b0001;
        tick();
        bus_idle();
        for (int k = 0; k < 10*BD; k++) begin
            check("uart_tx", {31'b0, uart_tx}, {31'b0, frame_bit(b, k)});
            check("uart_busy", {31'b0, uart_busy}, 32'd1);
            if (k == 7) check("status_busy", mem_rdata, 32'd1);
            if (k == 6) begin
                mem_addr  = A_USTA;
                mem_rstrb = 1'b1;
            end else if (k == 13 && drop_mid) begin
                mem_addr  = A_UDAT;
                mem_wdata = {24'h0, other};
                mem_wmask = 4'b0001;
            end else begin
                bus_idle();
            end
            tick();
        end
        bus_idle();
        m_rdata = 32'd1;
        $display("[TB] frame byte=%h drop_mid=%0d done busy=%0d", b, drop_mid, uart_busy);
        check("busy_end", {31'b0, uart_busy}, 32'd0);
        check("tx_end", {31'b0, uart_tx}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        mem_addr  = '0;
        mem_wdata = '0;
        bus_idle();
        m_rdata = '0;
        m_leds  = '0;
        repeat (3) tick();
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_leds", 32'(leds), 32'h0);
        check("rst_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_busy", {31'b0, uart_busy}, 32'd0);
        rst = 1'b0;
        tick();

        for (int w = 0; w < RW; w++) ram_op(w, $urandom, 4'hF, 1'b0);

        ram_op(4, 32'hAABBCCDD, 4'b1111, 1'b0);
        ram_op(4, 32'h11223344, 4'b0101, 1'b0);
        ram_op(4, 32'h0, 4'b0000, 1'b1);
        check("mask_merge", mem_rdata, 32'hAA22CC44);

        ram_op(RW, 32'hDEADBEEF, 4'hF, 1'b0);
        ram_op(RW, 32'h0, 4'b0000, 1'b1);
        check("oor_read", mem_rdata, 32'h0);
        ram_op(RW + 3, 32'h0, 4'b0000, 1'b1);

        ram_op(5, 32'h0BADF00D, 4'hF, 1'b0);
        ram_op(5, 32'hCAFEBABE, 4'hF, 1'b1);
        check("rd_before_wr", mem_rdata, 32'h0BADF00D);
        ram_op(5, 32'h0, 4'b0000, 1'b1);

        for (int n = 0; n < 150; n++)
            ram_op(int'($urandom_range(RW + 3, 0)), $urandom,
                   4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)));

        io_write(A_LED, 32'h1A5, 4'b0001);
        check("led_a5", 32'(leds), 32'hA5);
        io_write(A_LED, 32'hFF, 4'b0010);
        io_read("led_read", A_LED, 32'h0000_00A5);
        io_read("udat_read", A_UDAT, 32'h0);
        io_read("none_read", 32'h0040_0000, 32'h0);
        io_read("led_read2", A_LED, 32'(m_leds));
        io_read("multi_read", 32'h0040_000C, 32'h0);
        io_read("stat_idle", A_USTA, 32'h0);
        for (int n = 0; n < 6; n++)
            io_write(A_LED, $urandom, 4'($urandom_range(15, 0)));

        frame(8'h55, 1'b0);
        io_read("stat_after", A_USTA, 32'h0);
        frame(8'($urandom), 1'b1);
        for (int k = 0; k < 3*BD; k++) begin
            check("no_2nd_busy", {31'b0, uart_busy}, 32'd0);
            check("no_2nd_tx", {31'b0, uart_tx}, 32'd1);
            tick();
        end
        frame(8'($urandom), 1'b0);
        frame(8'($urandom), 1'b0);

        io_write(A_LED, 32'h3C, 4'b0001);
        mem_addr  = A_UDAT;
        mem_wdata = 32'hC3;
        mem_wmask = 4'b0001;
        tick();
        bus_idle();
        repeat (BD + 3) tick();
        check("pre_rst_tx_bit", {31'b0, uart_tx}, {31'b0, frame_bit(8'hC3, BD + 3)});
        rst = 1'b1;
        #1;
        m_leds  = '0;
        m_rdata = '0;
        $display("[TB] reset asserted mid-frame tx=%0d busy=%0d", uart_tx, uart_busy);
        check("midrst_tx", {31'b0, uart_tx}, 32'd1);
        check("midrst_busy", {31'b0, uart_busy}, 32'd0);
        check("midrst_leds", 32'(leds), 32'h0);
        check("midrst_rdata", mem_rdata, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_tx", {31'b0, uart_tx}, 32'd1);
        frame(8'h80, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
